wbu_rf_writer: RTL and testbench
================================

Name: wbu_rf_writer

Overview:
Writeback stage of the PQR5 core; drives the register file's single write port (wren, rdt_addr, rdt_data).
- Accepts completed instructions from the memory-access stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then extracts and sign- or zero-extends the load data.
- Issues one registered register-file write per committed instruction and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous reset, active-low
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  writeback can accept an instruction
- i_rdt_addr  in  5  destination register index
- i_wb_en  in  1  instruction writes a destination register
- i_is_load  in  1  instruction is a load
- i_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- i_result  in  XLEN  ALU result; for loads, the effective address
- i_dmem_ack  in  1  data-memory read response valid
- i_dmem_rdata  in  XLEN  data-memory read word, aligned to a word boundary
- o_rf_wren  out  1  register-file write enable
- o_rf_rdt_addr  out  5  register-file write address
- o_rf_rdt_data  out  XLEN  register-file write data
- o_instret  out  32  count of retired instructions
- o_err  out  1  one-cycle pulse on an illegal load funct3

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State RUN.
  - o_rf_wren=0, o_rf_rdt_addr=0, o_rf_rdt_data=0, o_instret=0, o_err=0.
  - o_ready=1 once reset is released.
- FSM states: RUN, LDWAIT.
  - o_ready = (state==RUN), decoded combinationally from the state register.
- Acceptance: an instruction is accepted when i_valid & o_ready; its fields are captured on that edge.
- RUN, accept of a non-load:
  - Next cycle, o_rf_wren = i_wb_en & |i_rdt_addr.
  - o_rf_rdt_addr = i_rdt_addr, o_rf_rdt_data = i_result.
  - o_instret increments. State remains RUN, giving back-to-back throughput of 1 per cycle.
- RUN, accept of a load:
  - Capture rdt_addr, wb_en, funct3 and addr[1:0]=i_result[1:0].
  - Go to LDWAIT; o_rf_wren=0 on the next cycle.
- LDWAIT:
  - o_ready=0; i_valid is ignored.
  - On i_dmem_ack=1, format the data, then on the next cycle:
    - o_rf_wren = wb_en & |rdt_addr.
    - o_rf_rdt_data = formatted value.
    - o_instret increments.
  - State returns to RUN.
  - Minimum load occupancy is 2 cycles (accept, then ack in the following cycle).
- Load formatting:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes the word through and ignores addr[1:0].
  - Misalignment is trapped upstream and not checked here.
- Illegal load funct3 (3, 6, 7):
  - The ack completes the load, but there is no register-file write.
  - o_err pulses for 1 cycle together with the would-be write cycle.
  - o_instret still increments.
- i_dmem_ack while in RUN is ignored; no state change, no write.
- x0: never written; wren is suppressed when rdt_addr==0.
  - The instruction still retires and o_instret increments.
- o_rf_wren is a 1-cycle pulse per commit. Address and data hold their last values while wren=0.
- o_instret wraps from 0xFFFF_FFFF to 0.
- Reset asserted mid-LDWAIT aborts the load: no write, state RUN. A later stale ack in RUN is ignored.
- All outputs are registered; o_ready is the only output decoded from state.

Test Plan:
- Back-to-back ALU ops, 3 consecutive cycles: (x5, 0x11), (x6, 0x22), (x7, 0x33), all wb_en=1 -> wren high for 3 consecutive cycles with matching addr/data; o_instret=3; o_ready stays 1.
- LB with addr=0x...02, rdata=0x1280_FF34 -> after ack, write 0xFFFF_FF80 to x9. LBU with the same inputs -> 0x0000_0080. o_ready=0 from the accept-next cycle until the ack cycle.
- LH with addr[1]=1, rdata=0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW -> 0x8001_7FFF.
- Writes to x0: ALU op with rdt=0, result=0xDEAD_BEEF, wb_en=1 -> wren stays 0; o_instret increments. Store-like op with wb_en=0 to x3 -> no write.
- Illegal funct3=3 load, ack after 4 wait cycles -> no write, o_err 1-cycle pulse. A stray ack in RUN -> no effect.
- Reset mid-LDWAIT, then a later ack -> no write; outputs 0, o_ready=1. o_instret forced to 0xFFFF_FFFF (by backdoor force) plus one retire -> wraps to 0.

Source files
------------

// File: rtl/wbu_rf_writer_if.sv
// Upstream valid/ready bundle between memory-access and writeback.
// Master drives the instruction fields; slave returns o_ready.
interface wbu_rf_writer_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_rdt_addr;
  logic            i_wb_en;
  logic            i_is_load;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_result;

  modport master (
    output i_valid,
    output i_rdt_addr,
    output i_wb_en,
    output i_is_load,
    output i_funct3,
    output i_result,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_rdt_addr,
    input  i_wb_en,
    input  i_is_load,
    input  i_funct3,
    input  i_result,
    output o_ready
  );
endinterface

// File: rtl/wbu_rf_writer.sv
// Writeback stage: commits ALU results and formatted load data to the RF.
// Ports: clk/aresetn, up (valid/ready instr bundle), dmem ack/rdata, RF write port, instret, err.
module wbu_rf_writer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  wbu_rf_writer_if.slave  up,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_rf_wren,
  output logic [4:0]      o_rf_rdt_addr,
  output logic [XLEN-1:0] o_rf_rdt_data,
  output logic [31:0]     o_instret,
  output logic            o_err
);

  typedef enum logic {
    RUN,
    LDWAIT
  } state_t;

  state_t          state;
  logic [4:0]      ld_rd;
  logic            ld_wb;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic            accept;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ld_data;
  logic            ld_ok;

  assign up.o_ready = (state == RUN);
  assign accept     = up.i_valid & up.o_ready;

  always_comb begin
    byte_sel = 8'h00;
    unique case (ld_off)
      2'd0: byte_sel = i_dmem_rdata[7:0];
      2'd1: byte_sel = i_dmem_rdata[15:8];
      2'd2: byte_sel = i_dmem_rdata[23:16];
      2'd3: byte_sel = i_dmem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = ld_off[1] ? i_dmem_rdata[31:16]
                              : i_dmem_rdata[15:0];

  always_comb begin
    ld_data = '0;
    ld_ok   = 1'b1;
    case (ld_f3)
      3'd0: ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'd1: ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'd2: ld_data = i_dmem_rdata;
      3'd4: ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'd5: ld_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= RUN;
      ld_rd         <= '0;
      ld_wb         <= 1'b0;
      ld_f3         <= '0;
      ld_off        <= '0;
      o_rf_wren     <= 1'b0;
      o_rf_rdt_addr <= '0;
      o_rf_rdt_data <= '0;
      o_instret     <= '0;
      o_err         <= 1'b0;
    end else begin
      o_rf_wren <= 1'b0;
      o_err     <= 1'b0;
      unique case (state)
        RUN: begin
          if (accept && up.i_is_load) begin
            ld_rd  <= up.i_rdt_addr;
            ld_wb  <= up.i_wb_en;
            ld_f3  <= up.i_funct3;
            ld_off <= up.i_result[1:0];
            state  <= LDWAIT;
          end else if (accept) begin
            o_rf_wren     <= up.i_wb_en & (|up.i_rdt_addr);
            o_rf_rdt_addr <= up.i_rdt_addr;
            o_rf_rdt_data <= up.i_result;
            o_instret     <= o_instret + 32'd1;
          end
        end
        LDWAIT: begin
          if (i_dmem_ack) begin
            state     <= RUN;
            o_instret <= o_instret + 32'd1;
            if (ld_ok) begin
              o_rf_wren     <= ld_wb & (|ld_rd);
              o_rf_rdt_addr <= ld_rd;
              o_rf_rdt_data <= ld_data;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_rf_writer.sv
// Directed self-checking bench for wbu_rf_writer.
// Drives on negedge, samples on the following negedge.
module tb_wbu_rf_writer;
  logic        clk;
  logic        aresetn;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        rf_wren;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] instret;
  logic        err;
  int          errors;
  int          checks;
  logic [31:0] exp_ret;

  wbu_rf_writer_if #(.XLEN(32)) up ();

  wbu_rf_writer #(.XLEN(32)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .up           (up.slave),
    .i_dmem_ack   (dmem_ack),
    .i_dmem_rdata (dmem_rdata),
    .o_rf_wren    (rf_wren),
    .o_rf_rdt_addr(rf_addr),
    .o_rf_rdt_data(rf_data),
    .o_instret    (instret),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    up.i_valid    = 1'b0;
    up.i_rdt_addr = '0;
    up.i_wb_en    = 1'b0;
    up.i_is_load  = 1'b0;
    up.i_funct3   = '0;
    up.i_result   = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic drive(input logic [4:0] rd, input logic wb,
                       input logic ld, input logic [2:0] f3,
                       input logic [31:0] res);
    up.i_valid    = 1'b1;
    up.i_rdt_addr = rd;
    up.i_wb_en    = wb;
    up.i_is_load  = ld;
    up.i_funct3   = f3;
    up.i_result   = res;
  endtask

  // Accept a load, hold waits cycles in LDWAIT, then ack.
  // Returns at the negedge after the ack edge.
  task automatic do_load(input string tag, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int waits);
    drive(rd, 1'b1, 1'b1, f3, addr);
    @(negedge clk);
    idle();
    chk({tag, "_ready_wait"}, {31'b0, up.o_ready}, 32'd0);
    chk({tag, "_wren_wait"}, {31'b0, rf_wren}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk({tag, "_ready_hold"}, {31'b0, up.o_ready}, 32'd0);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    idle();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_ret = 0;
    aresetn = 1'b0;
    idle();
    #12;
    chk("rst_wren", {31'b0, rf_wren}, 32'd0);
    chk("rst_addr", {27'b0, rf_addr}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, up.o_ready}, 32'd1);

    // back-to-back ALU ops
    drive(5'd5, 1'b1, 1'b0, 3'd0, 32'h11);
    @(negedge clk);
    chk("b2b0_wren", {31'b0, rf_wren}, 32'd1);
    chk("b2b0_addr", {27'b0, rf_addr}, 32'd5);
    chk("b2b0_data", rf_data, 32'h11);
    chk("b2b0_ready", {31'b0, up.o_ready}, 32'd1);
    drive(5'd6, 1'b1, 1'b0, 3'd0, 32'h22);
    @(negedge clk);
    chk("b2b1_wren", {31'b0, rf_wren}, 32'd1);
    chk("b2b1_addr", {27'b0, rf_addr}, 32'd6);
    chk("b2b1_data", rf_data, 32'h22);
    chk("b2b1_ready", {31'b0, up.o_ready}, 32'd1);
    drive(5'd7, 1'b1, 1'b0, 3'd0, 32'h33);
    @(negedge clk);
    idle();
    chk("b2b2_wren", {31'b0, rf_wren}, 32'd1);
    chk("b2b2_addr", {27'b0, rf_addr}, 32'd7);
    chk("b2b2_data", rf_data, 32'h33);
    exp_ret = 3;
    chk("b2b_instret", instret, exp_ret);
    @(negedge clk);
    chk("b2b_wren_pulse", {31'b0, rf_wren}, 32'd0);

    // loads
    do_load("lb", 5'd9, 3'd0, 32'h1000_0002, 32'h1280_FF34, 0);
    exp_ret++;
    chk("lb_wren", {31'b0, rf_wren}, 32'd1);
    chk("lb_addr", {27'b0, rf_addr}, 32'd9);
    chk("lb_data", rf_data, 32'hFFFF_FF80);
    chk("lb_ready", {31'b0, up.o_ready}, 32'd1);
    do_load("lbu", 5'd9, 3'd4, 32'h1000_0002, 32'h1280_FF34, 1);
    exp_ret++;
    chk("lbu_wren", {31'b0, rf_wren}, 32'd1);
    chk("lbu_data", rf_data, 32'h0000_0080);
    do_load("lh", 5'd10, 3'd1, 32'h2000_0002, 32'h8001_7FFF, 0);
    exp_ret++;
    chk("lh_wren", {31'b0, rf_wren}, 32'd1);
    chk("lh_addr", {27'b0, rf_addr}, 32'd10);
    chk("lh_data", rf_data, 32'hFFFF_8001);
    do_load("lhu", 5'd11, 3'd5, 32'h2000_0002, 32'h8001_7FFF, 0);
    exp_ret++;
    chk("lhu_data", rf_data, 32'h0000_8001);
    do_load("lw", 5'd12, 3'd2, 32'h2000_0003, 32'h8001_7FFF, 2);
    exp_ret++;
    chk("lw_addr", {27'b0, rf_addr}, 32'd12);
    chk("lw_data", rf_data, 32'h8001_7FFF);
    chk("ld_instret", instret, exp_ret);

    // x0 and wb_en=0
    drive(5'd0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();
    exp_ret++;
    chk("x0_wren", {31'b0, rf_wren}, 32'd0);
    chk("x0_instret", instret, exp_ret);
    drive(5'd3, 1'b0, 1'b0, 3'd0, 32'h1234_5678);
    @(negedge clk);
    idle();
    exp_ret++;
    chk("st_wren", {31'b0, rf_wren}, 32'd0);
    chk("st_instret", instret, exp_ret);

    // illegal funct3
    do_load("ill", 5'd13, 3'd3, 32'h0, 32'hAAAA_5555, 4);
    exp_ret++;
    chk("ill_wren", {31'b0, rf_wren}, 32'd0);
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_instret", instret, exp_ret);
    @(negedge clk);
    chk("ill_err_pulse", {31'b0, err}, 32'd0);

    // stray ack in RUN
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    idle();
    chk("stray_wren", {31'b0, rf_wren}, 32'd0);
    chk("stray_ready", {31'b0, up.o_ready}, 32'd1);
    chk("stray_instret", instret, exp_ret);

    // reset mid-LDWAIT
    drive(5'd14, 1'b1, 1'b1, 3'd2, 32'h0);
    @(negedge clk);
    idle();
    chk("abort_ready_wait", {31'b0, up.o_ready}, 32'd0);
    aresetn = 1'b0;
    #1;
    chk("abort_ready", {31'b0, up.o_ready}, 32'd1);
    chk("abort_instret", instret, 32'd0);
    chk("abort_data", rf_data, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    idle();
    chk("abort_ack_wren", {31'b0, rf_wren}, 32'd0);
    chk("abort_ack_instret", instret, 32'd0);
    chk("abort_ack_addr", {27'b0, rf_addr}, 32'd0);

    // instret wrap
    force dut.o_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.o_instret;
    chk("wrap_pre", instret, 32'hFFFF_FFFF);
    drive(5'd1, 1'b1, 1'b0, 3'd0, 32'h1);
    @(negedge clk);
    idle();
    chk("wrap_instret", instret, 32'd0);
    chk("wrap_wren", {31'b0, rf_wren}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
